// File: rtl/nmea_sentence_parser.sv
// rtl/nmea_sentence_parser.sv - NMEA-0183 sentence parser: framing, length, checksum, field count and field capture
module nmea_sentence_parser #(
  parameter int FIELD_BYTES      = 16,
  parameter int MAX_LEN          = 82,
  parameter bit REQUIRE_CHECKSUM = 1'b0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [7:0]               i_char,
  input  logic                     i_valid,
  input  logic [7:0]               i_field_sel,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_ok,
  output logic [2:0]               o_err,
  output logic [15:0]              o_talker,
  output logic [23:0]              o_sentence,
  output logic [7:0]               o_fieldcnt,
  output logic [8*FIELD_BYTES-1:0] o_field_data,
  output logic [7:0]               o_field_len
);

  typedef enum logic [2:0] {
    S_IDLE, S_TI, S_SI, S_DATA, S_CK_HI, S_CK_LO, S_CR, S_LF
  } state_t;

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] FB_MAX    = 8'(FIELD_BYTES);
  localparam logic [7:0] LEN_MAX   = 8'(MAX_LEN);

  localparam logic [2:0] E_OK    = 3'd0;
  localparam logic [2:0] E_CSUM  = 3'd1;
  localparam logic [2:0] E_HEX   = 3'd2;
  localparam logic [2:0] E_LONG  = 3'd3;
  localparam logic [2:0] E_ABORT = 3'd4;
  localparam logic [2:0] E_NOCK  = 3'd5;
  localparam logic [2:0] E_FRAME = 3'd6;
  localparam logic [2:0] E_TRUNC = 3'd7;

  // bit 4 flags a valid hex digit, bits 3:0 carry its value
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) begin
      hex_decode = {1'b1, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      hex_decode = {1'b1, c[3:0] + 4'd9};
    end else begin
      hex_decode = 5'd0;
    end
  endfunction

  state_t                   state_q, state_d;
  logic [1:0]               pos_q, pos_d;
  logic [7:0]               csum_q, csum_d;
  logic [7:0]               len_q, len_d;
  logic [7:0]               sel_q, sel_d;
  logic [3:0]               ck_hi_q, ck_hi_d;
  logic [2:0]               werr_q, werr_d;
  logic [15:0]              wtalker_q, wtalker_d;
  logic [23:0]              wsent_q, wsent_d;
  logic [7:0]               wfcnt_q, wfcnt_d;
  logic [7:0]               wflen_q, wflen_d;
  logic [8*FIELD_BYTES-1:0] wfdata_q, wfdata_d;

  logic                     done_q, done_d;
  logic                     ok_q, ok_d;
  logic [2:0]               err_q, err_d;
  logic [15:0]              talker_q, talker_d;
  logic [23:0]              sent_q, sent_d;
  logic [7:0]               fcnt_q, fcnt_d;
  logic [7:0]               flen_q, flen_d;
  logic [8*FIELD_BYTES-1:0] fdata_q, fdata_d;

  logic       fin;
  logic [2:0] fin_code;
  logic       start;
  logic [4:0] hx;

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    csum_d    = csum_q;
    len_d     = len_q;
    sel_d     = sel_q;
    ck_hi_d   = ck_hi_q;
    werr_d    = werr_q;
    wtalker_d = wtalker_q;
    wsent_d   = wsent_q;
    wfcnt_d   = wfcnt_q;
    wflen_d   = wflen_q;
    wfdata_d  = wfdata_q;
    done_d    = 1'b0;
    ok_d      = ok_q;
    err_d     = err_q;
    talker_d  = talker_q;
    sent_d    = sent_q;
    fcnt_d    = fcnt_q;
    flen_d    = flen_q;
    fdata_d   = fdata_q;
    fin       = 1'b0;
    fin_code  = E_OK;
    start     = 1'b0;
    hx        = hex_decode(i_char);

    if (i_valid) begin
      if (state_q == S_IDLE) begin
        start = (i_char == CH_DOLLAR);
      end else if (i_char == CH_DOLLAR) begin
        fin      = 1'b1;
        fin_code = E_ABORT;
        start    = 1'b1;
      end else if (len_q >= LEN_MAX) begin
        fin      = 1'b1;
        fin_code = E_LONG;
        len_d    = LEN_MAX + 8'd1;
      end else begin
        len_d = len_q + 8'd1;
        case (state_q)
          S_TI: begin
            csum_d    = csum_q ^ i_char;
            wtalker_d = {wtalker_q[7:0], i_char};
            pos_d     = pos_q + 2'd1;
            if (pos_q == 2'd1) begin
              state_d = S_SI;
              pos_d   = 2'd0;
            end
          end
          S_SI: begin
            csum_d  = csum_q ^ i_char;
            wsent_d = {wsent_q[15:0], i_char};
            pos_d   = pos_q + 2'd1;
            if (pos_q == 2'd2) begin
              state_d = S_DATA;
              pos_d   = 2'd0;
            end
          end
          S_DATA: begin
            if (i_char == CH_STAR) begin
              state_d = S_CK_HI;
            end else if (i_char == CH_CR) begin
              if (REQUIRE_CHECKSUM) begin
                fin      = 1'b1;
                fin_code = E_NOCK;
              end else begin
                state_d = S_LF;
              end
            end else begin
              csum_d = csum_q ^ i_char;
              if (i_char == CH_COMMA) begin
                wfcnt_d = wfcnt_q + 8'd1;
              end else if (sel_q != 8'd0 && wfcnt_q == sel_q) begin
                // a full buffer drops the character and flags truncation
                if (wflen_q < FB_MAX) begin
                  for (int k = 0; k < FIELD_BYTES; k++) begin
                    if (wflen_q == 8'(k)) wfdata_d[8*k +: 8] = i_char;
                  end
                  wflen_d = wflen_q + 8'd1;
                end else if (werr_q == E_OK) begin
                  werr_d = E_TRUNC;
                end
              end
            end
          end
          S_CK_HI: begin
            if (hx[4]) begin
              ck_hi_d = hx[3:0];
              state_d = S_CK_LO;
            end else begin
              fin      = 1'b1;
              fin_code = E_HEX;
            end
          end
          S_CK_LO: begin
            if (hx[4]) begin
              if ({ck_hi_q, hx[3:0]} != csum_q) werr_d = E_CSUM;
              state_d = S_CR;
            end else begin
              fin      = 1'b1;
              fin_code = E_HEX;
            end
          end
          S_CR: begin
            if (i_char == CH_CR) begin
              state_d = S_LF;
            end else begin
              fin      = 1'b1;
              fin_code = E_FRAME;
            end
          end
          S_LF: begin
            fin      = 1'b1;
            fin_code = (i_char == CH_LF) ? werr_q : E_FRAME;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    // outputs publish the working values accumulated before this character
    if (fin) begin
      state_d  = S_IDLE;
      done_d   = 1'b1;
      err_d    = fin_code;
      ok_d     = (fin_code == E_OK);
      talker_d = wtalker_q;
      sent_d   = wsent_q;
      fcnt_d   = wfcnt_q;
      flen_d   = wflen_q;
      fdata_d  = wfdata_q;
    end

    if (start) begin
      state_d   = S_TI;
      pos_d     = 2'd0;
      csum_d    = 8'd0;
      len_d     = 8'd1;
      sel_d     = i_field_sel;
      ck_hi_d   = 4'd0;
      werr_d    = E_OK;
      wtalker_d = 16'd0;
      wsent_d   = 24'd0;
      wfcnt_d   = 8'd0;
      wflen_d   = 8'd0;
      wfdata_d  = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= S_IDLE;
      pos_q     <= 2'd0;
      csum_q    <= 8'd0;
      len_q     <= 8'd0;
      sel_q     <= 8'd0;
      ck_hi_q   <= 4'd0;
      werr_q    <= E_OK;
      wtalker_q <= 16'd0;
      wsent_q   <= 24'd0;
      wfcnt_q   <= 8'd0;
      wflen_q   <= 8'd0;
      wfdata_q  <= '0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 3'd0;
      talker_q  <= 16'd0;
      sent_q    <= 24'd0;
      fcnt_q    <= 8'd0;
      flen_q    <= 8'd0;
      fdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      csum_q    <= csum_d;
      len_q     <= len_d;
      sel_q     <= sel_d;
      ck_hi_q   <= ck_hi_d;
      werr_q    <= werr_d;
      wtalker_q <= wtalker_d;
      wsent_q   <= wsent_d;
      wfcnt_q   <= wfcnt_d;
      wflen_q   <= wflen_d;
      wfdata_q  <= wfdata_d;
      done_q    <= done_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      talker_q  <= talker_d;
      sent_q    <= sent_d;
      fcnt_q    <= fcnt_d;
      flen_q    <= flen_d;
      fdata_q   <= fdata_d;
    end
  end

  assign o_busy       = (state_q != S_IDLE);
  assign o_done       = done_q;
  assign o_ok         = ok_q;
  assign o_err        = err_q;
  assign o_talker     = talker_q;
  assign o_sentence   = sent_q;
  assign o_fieldcnt   = fcnt_q;
  assign o_field_data = fdata_q;
  assign o_field_len  = flen_q;

endmodule

// File: doc/nmea_sentence_parser.md
# nmea_sentence_parser

Parametrised successor to the team's NMEA receiver. It consumes the character stream produced by the UART character receiver (`char_r`) and parses NMEA-0183 sentences of the form `$TTSSS,f1,f2,...*HH<CR><LF>`. It validates framing, length and the XOR checksum, counts data fields, and captures one runtime-selected field into a byte buffer. It reports every sentence, good or bad, with a single-cycle completion strobe and an error code. It sits between `char_r` and the downstream GPS/data consumers.

## Interface
Parameters:
- `FIELD_BYTES`, default 16: capacity of the field capture buffer, in bytes.
- `MAX_LEN`, default 82: maximum sentence length in characters, counted from `$` through `<LF>` inclusive.
- `REQUIRE_CHECKSUM`, default 0: when 1, a sentence without `*HH` is a fatal error.

Ports (reset: one clock; reset is synchronous and active-low):
- `i_clk`  in  1  clock.
- `i_rst`  in  1  synchronous, active-low reset.
- `i_char`  in  8  received character; meaningful only while `i_valid` is high.
- `i_valid`  in  1  one-cycle character strobe (the `char_r` finished signal); may be high on consecutive cycles.
- `i_field_sel`  in  8  1-based index of the field to capture; 0 disables capture; sampled when `$` is accepted.
- `o_busy`  out  1  high when the state is not IDLE.
- `o_done`  out  1  one-cycle pulse marking the end of a sentence (good or bad).
- `o_ok`  out  1  high when the last finished sentence had error code 0.
- `o_err`  out  3  error code of the last finished sentence.
- `o_talker`  out  16  talker ID; first character in bits [15:8].
- `o_sentence`  out  24  sentence ID; first character in bits [23:16].
- `o_fieldcnt`  out  8  number of `,` characters seen in the data region.
- `o_field_data`  out  8*FIELD_BYTES  captured field; character k at bits [8k+7:8k]; unused bytes are 0.
- `o_field_len`  out  8  number of captured bytes, saturating at FIELD_BYTES.

## Operation
- States: IDLE, TI, SI, DATA, CK_HI, CK_LO, CR, LF. Only cycles with `i_valid` high advance the state or update any register.
- IDLE: `$` starts a sentence. It clears the working registers, the checksum, the length counter (to 1) and the error code, and latches `i_field_sel`. All other characters are ignored.
- TI: takes 2 characters. SI: takes 3 characters. Every character in TI, SI and DATA is XORed into the running checksum.
- DATA:
  - `,` increments the field count. The field after the k-th comma is field k.
  - While the current field number equals the selected field, characters go into the capture buffer.
  - `*` goes to CK_HI and is not XORed into the checksum.
  - `<CR>` goes to LF. With `REQUIRE_CHECKSUM`=1 this is fatal error 5.
- CK_HI / CK_LO: each takes one hex digit (0-9, A-F, a-f). Any other character is fatal error 2. In CK_LO, if the received byte differs from the running checksum, non-fatal error 1 is latched.
- CR: expects `<CR>`. LF: expects `<LF>`. Any other character in either state is fatal error 6.
- Error codes: 0 ok, 1 checksum mismatch, 2 bad hex digit, 3 overlength, 4 aborted by `$`, 5 missing checksum, 6 framing, 7 field truncated.
- Fatal errors (2, 3, 4, 5, 6):
  - Raise `o_done` immediately and return to IDLE.
  - Override any latched non-fatal code.
- Non-fatal errors: 7 is latched when a character would exceed FIELD_BYTES; that character is dropped. Code 1 overrides 7.
- `$` in any non-IDLE state is error 4: finish the current sentence with `o_done`, then start a new sentence in the same cycle.
- Length: when the count would exceed MAX_LEN, raise fatal error 3.
- At every `o_done`, the working talker, sentence, fieldcnt, field data and field length are copied to the outputs, even partial values. All outputs hold until the next `o_done`. `o_ok` is 1 only when `o_err` is 0.

## Timing
- Synchronous reset: all outputs go to 0 and the state to IDLE. Reset mid-sentence discards the sentence and produces no `o_done`.
- `o_done`, `o_err`, `o_ok` and the data outputs update on the clock edge that accepts the terminating character. `o_done` is high for exactly that following cycle.
- Back-to-back `i_valid` is supported: one character per cycle, no stall.
- An abort by `$` and the new sentence start happen in one cycle. `o_busy` stays 1.
- The checksum is 8-bit XOR. The field count wraps modulo 256. The length counter is 8-bit and stops at MAX_LEN+1.

## Test plan
- `$GPGLL,4916.45,N,12311.12,W,225444,A,*1D\r\n`, sel=3 -> `o_done`, ok=1, err=0, talker=0x4750, sentence=0x474C4C, fieldcnt=7, len=8, field = "12311.12".
- Same sentence with `*1E` -> done at `<LF>`, err=1, ok=0, fieldcnt=7.
- `$GPGLL,4916.45*1G` -> done on `G`, err=2, state back to IDLE.
- `$GPGLL,4916` followed by `$GPGLL,...*1D\r\n` -> first done with err=4, second done with err=0. `o_busy` stays high throughout.
- A 90-character sentence with MAX_LEN=82 -> done on character 83, err=3. Separately, a 20-character field with FIELD_BYTES=16 -> err=7, len=16.
- `$GPGLL,A\r\n`: with REQUIRE_CHECKSUM=0 -> ok=1, fieldcnt=1. With REQUIRE_CHECKSUM=1 -> err=5 on `<CR>`. Reset asserted mid-sentence -> no done, all outputs 0.
